// File: rtl/pkt_buffer_scheduler.sv
// pkt_buffer_scheduler: packet-granular ingress arbiter and dequeue read sequencer for a shared buffer free-list manager
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   s_req_valid/last/ready   per-port ingress word handshake (NUM_PORTS wide)
//   m_wr_sel, m_wr_addr      granted port index and buffer write address
//   am_*                     free-list manager strobes, read start address and status
//   m_desc_*                 one-cycle enqueue descriptor {addr, len, port}
//   s_deq_valid/addr/len     dequeue command {start address, length}, s_deq_ready accepts
//   m_rd_valid/addr/last     per-word buffer read-address stream
//   m_stat_wr_pkts/rd_pkts   packet counters, live only with PKT_BUFFER_SCHEDULER_STATS_EN
module pkt_buffer_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int PORT_IDX_WIDTH = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter int LEN_WIDTH      = 8,
    parameter int MAX_PKT_WORDS  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      s_req_valid,
    input  logic [NUM_PORTS-1:0]      s_req_last,
    output logic [NUM_PORTS-1:0]      s_req_ready,
    output logic [PORT_IDX_WIDTH-1:0] m_wr_sel,
    output logic [ADDR_WIDTH-1:0]     m_wr_addr,
    output logic                      am_wr_en,
    output logic                      am_rd_en,
    output logic                      am_first_word_en,
    output logic [ADDR_WIDTH-1:0]     am_rd_addr,
    input  logic [ADDR_WIDTH-1:0]     am_fl_head,
    input  logic [ADDR_WIDTH-1:0]     am_rd_next_addr,
    input  logic                      am_almost_full,
    input  logic                      am_is_empty,
    output logic                      m_desc_valid,
    output logic [ADDR_WIDTH-1:0]     m_desc_addr,
    output logic [LEN_WIDTH-1:0]      m_desc_len,
    output logic [PORT_IDX_WIDTH-1:0] m_desc_port,
    input  logic                      s_deq_valid,
    input  logic [ADDR_WIDTH-1:0]     s_deq_addr,
    input  logic [LEN_WIDTH-1:0]      s_deq_len,
    output logic                      s_deq_ready,
    output logic                      m_rd_valid,
    output logic [ADDR_WIDTH-1:0]     m_rd_addr,
    output logic                      m_rd_last,
    output logic [31:0]               m_stat_wr_pkts,
    output logic [31:0]               m_stat_rd_pkts
);
    typedef enum logic {W_IDLE, W_PKT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FIRST, R_LINK, R_BODY} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [PORT_IDX_WIDTH-1:0] grant, rr_ptr, pick;
    logic [LEN_WIDTH-1:0]      len_cnt, len_inc, remaining;
    logic [ADDR_WIDTH-1:0]     pkt_addr, rd_addr_q;
    logic                      accept;
    // Scan from farthest to nearest so the nearest valid port after rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_PORTS; i >= 1; i--)
            if (s_req_valid[(int'(rr_ptr) + i) % NUM_PORTS])
                pick = PORT_IDX_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
    end
    assign len_inc   = (len_cnt == '1) ? len_cnt : len_cnt + 1'b1;
    assign m_wr_sel  = grant;
    assign m_wr_addr = am_fl_head;
    assign am_wr_en  = accept;
    always_comb begin
        w_next      = w_state;
        s_req_ready = '0;
        accept      = 1'b0;
        case (w_state)
            W_IDLE: if (|s_req_valid && !am_almost_full) w_next = W_PKT;
            W_PKT: begin
                s_req_ready[grant] = s_req_valid[grant];
                accept             = s_req_valid[grant];
                if (accept && s_req_last[grant]) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end
    always_ff @(posedge clk) w_state <= rst ? W_IDLE : w_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= '0;
            rr_ptr       <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
            len_cnt      <= '0;
            pkt_addr     <= '0;
            m_desc_valid <= 1'b0;
            m_desc_addr  <= '0;
            m_desc_len   <= '0;
            m_desc_port  <= '0;
        end else begin
            m_desc_valid <= 1'b0;
            if (w_state == W_IDLE && w_next == W_PKT) begin
                grant   <= pick;
                rr_ptr  <= pick;
                len_cnt <= '0;
            end
            if (accept) begin
                len_cnt <= len_inc;
                // len_cnt is zero only before the first word (it saturates, never wraps).
                if (len_cnt == '0) pkt_addr <= am_fl_head;
                if (s_req_last[grant]) begin
                    m_desc_valid <= 1'b1;
                    m_desc_addr  <= (len_cnt == '0) ? am_fl_head : pkt_addr;
                    m_desc_len   <= len_inc;
                    m_desc_port  <= grant;
                end
            end
        end
    end
    assign am_rd_addr = rd_addr_q;
    always_comb begin
        r_next           = r_state;
        s_deq_ready      = 1'b0;
        am_rd_en         = 1'b0;
        am_first_word_en = 1'b0;
        m_rd_valid       = 1'b0;
        m_rd_addr        = '0;
        m_rd_last        = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_deq_ready = !am_is_empty;
                if (s_deq_valid && !am_is_empty) r_next = R_FIRST;
            end
            R_FIRST: begin
                am_first_word_en = 1'b1;
                am_rd_en         = 1'b1;
                m_rd_valid       = 1'b1;
                m_rd_addr        = rd_addr_q;
                m_rd_last        = remaining == '0;
                r_next           = R_LINK;
            end
            // Bubble while the manager resolves the link to the second word.
            R_LINK: r_next = (remaining != '0) ? R_BODY : R_IDLE;
            R_BODY: begin
                am_rd_en   = 1'b1;
                m_rd_valid = 1'b1;
                m_rd_addr  = am_rd_next_addr;
                m_rd_last  = remaining == LEN_WIDTH'(1);
                r_next     = m_rd_last ? R_IDLE : R_BODY;
            end
            default: r_next = R_IDLE;
        endcase
    end
    always_ff @(posedge clk) r_state <= rst ? R_IDLE : r_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            remaining <= '0;
        end else if (r_state == R_IDLE && r_next == R_FIRST) begin
            rd_addr_q <= s_deq_addr;
            // Zero length is treated as one word, so nothing remains after the first.
            remaining <= (s_deq_len == '0) ? '0 : s_deq_len - 1'b1;
        end else if (r_state == R_BODY) begin
            remaining <= remaining - 1'b1;
        end
    end
`ifdef PKT_BUFFER_SCHEDULER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_stat_wr_pkts <= '0;
            m_stat_rd_pkts <= '0;
        end else begin
            if (m_desc_valid) m_stat_wr_pkts <= m_stat_wr_pkts + 1'b1;
            if (m_rd_last) m_stat_rd_pkts <= m_stat_rd_pkts + 1'b1;
        end
    end
`else
    assign m_stat_wr_pkts = '0;
    assign m_stat_rd_pkts = '0;
`endif
endmodule

// File: tb/tb_pkt_buffer_scheduler.sv
// tb_pkt_buffer_scheduler: directed self-checking bench for pkt_buffer_scheduler
module tb_pkt_buffer_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_req_valid = '0, s_req_last = '0, s_req_ready;
    logic [1:0]  m_wr_sel, m_desc_port;
    logic [11:0] m_wr_addr, am_rd_addr, m_desc_addr, m_rd_addr;
    logic [11:0] am_fl_head = 12'd5, am_rd_next_addr = '0, s_deq_addr = '0;
    logic        am_wr_en, am_rd_en, am_first_word_en, m_desc_valid, s_deq_ready;
    logic        am_almost_full = 1'b0, am_is_empty = 1'b1, s_deq_valid = 1'b0;
    logic        m_rd_valid, m_rd_last;
    logic [7:0]  m_desc_len, s_deq_len = '0;
    logic [31:0] m_stat_wr_pkts, m_stat_rd_pkts;
    int          n_tests = 0, n_fail = 0;

    pkt_buffer_scheduler dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_last(s_req_last), .s_req_ready(s_req_ready),
        .m_wr_sel(m_wr_sel), .m_wr_addr(m_wr_addr),
        .am_wr_en(am_wr_en), .am_rd_en(am_rd_en), .am_first_word_en(am_first_word_en),
        .am_rd_addr(am_rd_addr), .am_fl_head(am_fl_head), .am_rd_next_addr(am_rd_next_addr),
        .am_almost_full(am_almost_full), .am_is_empty(am_is_empty),
        .m_desc_valid(m_desc_valid), .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len),
        .m_desc_port(m_desc_port),
        .s_deq_valid(s_deq_valid), .s_deq_addr(s_deq_addr), .s_deq_len(s_deq_len),
        .s_deq_ready(s_deq_ready),
        .m_rd_valid(m_rd_valid), .m_rd_addr(m_rd_addr), .m_rd_last(m_rd_last),
        .m_stat_wr_pkts(m_stat_wr_pkts), .m_stat_rd_pkts(m_stat_rd_pkts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", s_req_ready, 0);
        check("rst_wr_en", am_wr_en, 0);
        check("rst_wr_addr", m_wr_addr, 5);
        check("rst_desc_valid", m_desc_valid, 0);
        check("rst_rd_valid", m_rd_valid, 0);
        check("rst_deq_ready", s_deq_ready, 0);
        check("rst_stat_wr", m_stat_wr_pkts, 0);
        rst = 1'b0;
        // port 1, 3-word packet at head 5
        @(negedge clk); s_req_valid = 4'b0010; #1;
        check("s1_c0_ready", s_req_ready, 0);
        @(negedge clk); #1;
        check("s1_c1_ready", s_req_ready, 4'b0010);
        check("s1_c1_wr_en", am_wr_en, 1);
        check("s1_c1_sel", m_wr_sel, 1);
        check("s1_c1_wr_addr", m_wr_addr, 5);
        @(negedge clk); am_fl_head = 12'd6; #1;
        check("s1_c2_wr_en", am_wr_en, 1);
        @(negedge clk); am_fl_head = 12'd7; s_req_last = 4'b0010; #1;
        check("s1_c3_wr_en", am_wr_en, 1);
        check("s1_c3_desc_early", m_desc_valid, 0);
        @(negedge clk); s_req_valid = '0; s_req_last = '0; #1;
        check("s1_desc_valid", m_desc_valid, 1);
        check("s1_desc_addr", m_desc_addr, 5);
        check("s1_desc_len", m_desc_len, 3);
        check("s1_desc_port", m_desc_port, 1);
        check("s1_c4_wr_en", am_wr_en, 0);
        @(negedge clk); #1;
        check("s1_desc_pulse", m_desc_valid, 0);
        // round robin from pointer 3: ports 0, 2, 3
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; s_req_valid = 4'b1101; s_req_last = 4'b1101; #1;
        check("s2_idle0", s_req_ready, 0);
        @(negedge clk); #1;
        check("s2_g0_ready", s_req_ready, 4'b0001);
        check("s2_g0_sel", m_wr_sel, 0);
        @(negedge clk); s_req_valid = 4'b1100; s_req_last = 4'b1100; #1;
        check("s2_idle1", s_req_ready, 0);
        check("s2_d0_port", m_desc_port, 0);
        check("s2_d0_len", m_desc_len, 1);
        @(negedge clk); #1;
        check("s2_g2_ready", s_req_ready, 4'b0100);
        check("s2_g2_sel", m_wr_sel, 2);
        @(negedge clk); s_req_valid = 4'b1000; s_req_last = 4'b1000; #1;
        check("s2_idle2", s_req_ready, 0);
        check("s2_d2_port", m_desc_port, 2);
        @(negedge clk); #1;
        check("s2_g3_ready", s_req_ready, 4'b1000);
        check("s2_g3_sel", m_wr_sel, 3);
        @(negedge clk); s_req_valid = '0; s_req_last = '0; #1;
        check("s2_d3_valid", m_desc_valid, 1);
        check("s2_d3_port", m_desc_port, 3);
        // almost-full gating
        @(negedge clk); am_almost_full = 1'b1; s_req_valid = 4'b0001; #1;
        check("s3_af_ready0", s_req_ready, 0);
        @(negedge clk); #1;
        check("s3_af_ready1", s_req_ready, 0);
        check("s3_af_wr_en", am_wr_en, 0);
        @(negedge clk); am_almost_full = 1'b0; #1;
        check("s3_fall_ready", s_req_ready, 0);
        @(negedge clk); am_almost_full = 1'b1; #1;
        check("s3_grant_ready", s_req_ready, 4'b0001);
        check("s3_grant_wr_en", am_wr_en, 1);
        @(negedge clk); s_req_last = 4'b0001; #1;
        check("s3_mid_af_ready", s_req_ready, 4'b0001);
        @(negedge clk); s_req_valid = '0; s_req_last = '0; am_almost_full = 1'b0; #1;
        check("s3_desc_valid", m_desc_valid, 1);
        check("s3_desc_len", m_desc_len, 2);
        check("s3_desc_addr", m_desc_addr, 7);
        // dequeue {7, 3}
        @(negedge clk); am_is_empty = 1'b0; s_deq_valid = 1'b1; s_deq_addr = 12'd7; s_deq_len = 8'd3; #1;
        check("s4_deq_ready", s_deq_ready, 1);
        @(negedge clk); s_deq_valid = 1'b0; #1;
        check("s4_f_valid", m_rd_valid, 1);
        check("s4_f_addr", m_rd_addr, 7);
        check("s4_f_first", am_first_word_en, 1);
        check("s4_f_rd_en", am_rd_en, 1);
        check("s4_f_am_addr", am_rd_addr, 7);
        check("s4_f_last", m_rd_last, 0);
        check("s4_f_deq_ready", s_deq_ready, 0);
        @(negedge clk); am_rd_next_addr = 12'd9; #1;
        check("s4_l_valid", m_rd_valid, 0);
        check("s4_l_rd_en", am_rd_en, 0);
        check("s4_l_am_addr", am_rd_addr, 7);
        @(negedge clk); #1;
        check("s4_b1_addr", m_rd_addr, 9);
        check("s4_b1_valid", m_rd_valid, 1);
        check("s4_b1_first", am_first_word_en, 0);
        check("s4_b1_last", m_rd_last, 0);
        @(negedge clk); am_rd_next_addr = 12'd12; #1;
        check("s4_b2_addr", m_rd_addr, 12);
        check("s4_b2_last", m_rd_last, 1);
        check("s4_b2_rd_en", am_rd_en, 1);
        @(negedge clk); #1;
        check("s4_end_valid", m_rd_valid, 0);
        check("s4_end_deq_ready", s_deq_ready, 1);
        // single-word dequeues, length 0 and 1
        for (int l = 0; l < 2; l++) begin
            @(negedge clk); s_deq_valid = 1'b1; s_deq_addr = 12'd30; s_deq_len = 8'(l); #1;
            check("s5_deq_ready", s_deq_ready, 1);
            @(negedge clk); s_deq_valid = 1'b0; #1;
            check("s5_valid", m_rd_valid, 1);
            check("s5_addr", m_rd_addr, 30);
            check("s5_last", m_rd_last, 1);
            @(negedge clk); #1;
            check("s5_link_valid", m_rd_valid, 0);
            check("s5_link_deq_ready", s_deq_ready, 0);
            @(negedge clk); #1;
            check("s5_idle_deq_ready", s_deq_ready, 1);
            check("s5_idle_valid", m_rd_valid, 0);
        end
        @(negedge clk); am_is_empty = 1'b1; s_deq_valid = 1'b1; #1;
        check("s5_empty_deq_ready", s_deq_ready, 0);
        @(negedge clk); #1;
        check("s5_empty_no_read", m_rd_valid, 0);
        s_deq_valid = 1'b0; am_is_empty = 1'b0;
        // simultaneous write packet and dequeue
        @(negedge clk); s_req_valid = 4'b0100; s_deq_valid = 1'b1; s_deq_addr = 12'd40; s_deq_len = 8'd2; #1;
        check("s6_deq_ready", s_deq_ready, 1);
        check("s6_wr_idle", s_req_ready, 0);
        @(negedge clk); s_deq_valid = 1'b0; #1;
        check("s6_overlap_wr", am_wr_en, 1);
        check("s6_overlap_rd", am_rd_en, 1);
        check("s6_overlap_first", am_first_word_en, 1);
        @(negedge clk); s_req_last = 4'b0100; #1;
        check("s6_w2_wr_en", am_wr_en, 1);
        check("s6_link_rd_en", am_rd_en, 0);
        @(negedge clk); s_req_valid = '0; s_req_last = '0; am_rd_next_addr = 12'd41; #1;
        check("s6_desc_port", m_desc_port, 2);
        check("s6_desc_len", m_desc_len, 2);
        check("s6_body_addr", m_rd_addr, 41);
        check("s6_body_last", m_rd_last, 1);
        // reset mid-packet, last word coincident with reset
        @(negedge clk); s_req_valid = 4'b0010; #1;
        check("s7_idle_ready", s_req_ready, 0);
        @(negedge clk); #1;
        check("s7_w1_wr_en", am_wr_en, 1);
        @(negedge clk); s_req_last = 4'b0010; rst = 1'b1;
        @(negedge clk); s_req_valid = '0; s_req_last = '0; #1;
        check("s7_rst_desc", m_desc_valid, 0);
        check("s7_rst_wr_en", am_wr_en, 0);
        check("s7_rst_ready", s_req_ready, 0);
        check("s7_rst_rd_valid", m_rd_valid, 0);
        check("s7_rst_stat_wr", m_stat_wr_pkts, 0);
        check("s7_rst_stat_rd", m_stat_rd_pkts, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("s7_post_desc", m_desc_valid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_buffer_scheduler.md
Name: pkt_buffer_scheduler

Overview:
- Sequences the shared packet buffer's free-list address manager.
- Arbitrates NUM_PORTS ingress writers at packet granularity, round-robin, gated by almost-full.
- Drives the manager's write, read and first-word strobes; emits an enqueue descriptor per stored packet.
- Executes dequeue commands (start address, length) as a per-word buffer read-address stream.

Parameters:
NUM_PORTS, 4, number of ingress write requesters
PORT_IDX_WIDTH, 2, width of a port index (clog2 NUM_PORTS)
ADDR_WIDTH, 12, buffer word address width
LEN_WIDTH, 8, packet length field width in words
MAX_PKT_WORDS, 32, largest legal packet; must not exceed the manager's almost-full threshold

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous active-high reset
s_req_valid  in  NUM_PORTS  per-port write word valid
s_req_last  in  NUM_PORTS  per-port last word of packet
s_req_ready  out  NUM_PORTS  per-port word accept
m_wr_sel  out  PORT_IDX_WIDTH  granted port index, for the external data mux
m_wr_addr  out  ADDR_WIDTH  buffer write address (= am_fl_head)
am_wr_en  out  1  manager write strobe
am_rd_en  out  1  manager read strobe
am_first_word_en  out  1  manager first-word strobe
am_rd_addr  out  ADDR_WIDTH  manager read start address
am_fl_head  in  ADDR_WIDTH  manager free-list head
am_rd_next_addr  in  ADDR_WIDTH  manager next readable address
am_almost_full  in  1  manager almost-full flag
am_is_empty  in  1  manager empty flag
m_desc_valid  out  1  one-cycle descriptor pulse
m_desc_addr  out  ADDR_WIDTH  first-word address of the stored packet
m_desc_len  out  LEN_WIDTH  stored length in words
m_desc_port  out  PORT_IDX_WIDTH  source port
s_deq_valid  in  1  dequeue command valid
s_deq_addr  in  ADDR_WIDTH  packet start address
s_deq_len  in  LEN_WIDTH  packet length in words
s_deq_ready  out  1  dequeue command accept
m_rd_valid  out  1  read address valid
m_rd_addr  out  ADDR_WIDTH  buffer read address
m_rd_last  out  1  last read word

Behaviour:
- Reset: both FSMs idle; round-robin pointer = NUM_PORTS-1; counters = 0.
- Reset: all outputs 0, except m_wr_addr = am_fl_head, which is combinational.
- Reset mid-packet: abandons the packet; no descriptor is issued.
- Write FSM states: W_IDLE, W_PKT.
  - W_IDLE: if any s_req_valid and !am_almost_full, grant the first valid port after the pointer, wrapping from NUM_PORTS-1 to 0. Register grant and pointer, go to W_PKT. Grant latency is 1 cycle.
  - W_PKT: s_req_ready[grant] = s_req_valid[grant]; all other ready bits are 0.
  - Each accepted word: am_wr_en = 1 in the same cycle.
  - First word: capture am_fl_head into the descriptor address.
  - Length counter increments per word and saturates at 2^LEN_WIDTH-1.
  - Accepted last word: m_desc_valid pulses on the next cycle; return to W_IDLE.
  - One idle cycle between packets, even from the same port.
  - almost_full rising mid-packet is ignored.
- Read FSM states: R_IDLE, R_FIRST, R_LINK, R_BODY.
  - R_IDLE: s_deq_ready = !am_is_empty. On accept, latch addr and len (len 0 treated as 1), go to R_FIRST.
  - R_FIRST: am_first_word_en = 1, am_rd_en = 1, am_rd_addr = m_rd_addr = latched addr, m_rd_valid = 1. m_rd_last = 1 if len == 1. Go to R_LINK.
  - R_LINK: all strobes 0; am_rd_addr held; m_rd_valid = 0. Go to R_BODY if remaining > 0, else R_IDLE.
  - R_BODY: each cycle am_rd_en = 1, m_rd_valid = 1, m_rd_addr = am_rd_next_addr, remaining decrements. m_rd_last on the final word, then R_IDLE.
- Write and read paths are independent; am_wr_en and am_rd_en may assert in the same cycle.
- First-word commands never overlap: the next accept happens in R_IDLE only.

Optional Feature:
- Macro: PKT_BUFFER_SCHEDULER_STATS_EN.
- Defined: adds outputs m_stat_wr_pkts[31:0] and m_stat_rd_pkts[31:0].
  - Incremented on m_desc_valid and on m_rd_last respectively.
  - Wrap modulo 2^32; cleared by rst.
- Undefined: both ports present, tied to 0; no counter logic.

Test Plan:
- Port 1 sends a 3-word packet, am_fl_head = 5 → grant 1 cycle after valid; 3 am_wr_en pulses; desc {addr 5, len 3, port 1}; one pulse.
- Ports 0, 2, 3 all valid with 1-word packets, pointer 3 → grants 0, 2, 3 in order, each separated by one idle cycle.
- am_almost_full = 1 with port 0 valid → no grant, ready 0. Flag falls → grant next cycle. Flag rises mid-packet → packet completes.
- Dequeue {addr 7, len 3}, am_rd_next_addr 9 then 12 → m_rd_addr 7, bubble, 9, 12, last on 12; first_word_en only with 7.
- Dequeue len 0 or 1 → single word, m_rd_last = 1, back to R_IDLE after R_LINK. am_is_empty = 1 → s_deq_ready = 0.
- Simultaneous write packet and dequeue → am_wr_en and am_rd_en overlap. rst mid-packet → outputs 0, no descriptor, stats 0.
